// File: rtl/pipe_sched.sv
// Pipeline sequencing controller for the five-stage MIPS core.
// Decides each cycle whether PC and IF/ID advance, hold or flush, whether a
// bubble enters E, owns the multiply/divide busy counter and redirects fetch
// on exception entry and eret. All control outputs are combinational from
// the registered state/counter and the current inputs.
module pipe_sched #(
    parameter int MULT_CYC = 5,
    parameter int DIV_CYC  = 10
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [4:0] rs_d,
    input  logic [4:0] rt_d,
    input  logic [1:0] tuse_rs_d,
    input  logic [1:0] tuse_rt_d,
    input  logic [4:0] a_e,
    input  logic [4:0] a_m,
    input  logic [1:0] tnew_e,
    input  logic [1:0] tnew_m,
    input  logic       md_use_d,
    input  logic       md_start_e,
    input  logic       md_div_e,
    input  logic       eret_d,
    input  logic       epc_wr_e,
    input  logic       epc_wr_m,
    input  logic       exc_req_m,
    output logic       en_pc,
    output logic       en_d,
    output logic       sel_d,
    output logic       clr_e,
    output logic       flush_all,
    output logic [1:0] pc_sel,
    output logic       md_busy,
    output logic       stall,
    output logic       state_dbg
);

    typedef enum logic {
        NORMAL    = 1'b0,
        EXC_FLUSH = 1'b1
    } state_t;

    localparam logic [3:0] MULT_LD = 4'(MULT_CYC);
    localparam logic [3:0] DIV_LD  = 4'(DIV_CYC);

    state_t     state;
    logic [3:0] cnt;

    logic data_stall;
    logic md_stall;
    logic epc_stall;
    logic stall_raw;
    logic exc_take;

    // Register-read hazards: a producer in E or M whose result arrives later
    // than the D instruction needs it. Register 0 never creates a hazard and
    // tuse=3 can never be exceeded by a 2-bit tnew.
    always_comb begin
        data_stall = 1'b0;
        if (rs_d != 5'd0 && rs_d == a_e && tnew_e > tuse_rs_d) data_stall = 1'b1;
        if (rs_d != 5'd0 && rs_d == a_m && tnew_m > tuse_rs_d) data_stall = 1'b1;
        if (rt_d != 5'd0 && rt_d == a_e && tnew_e > tuse_rt_d) data_stall = 1'b1;
        if (rt_d != 5'd0 && rt_d == a_m && tnew_m > tuse_rt_d) data_stall = 1'b1;
    end

    assign md_busy   = (cnt != 4'd0);
    assign md_stall  = md_use_d && (md_busy || md_start_e);
    assign epc_stall = eret_d && (epc_wr_e || epc_wr_m);
    assign stall_raw = data_stall || md_stall || epc_stall;
    // A new exception is only taken in NORMAL; during EXC_FLUSH it is ignored.
    assign exc_take  = exc_req_m && (state == NORMAL);
    assign state_dbg = state;

    // Output priority: exception entry, then stall, then eret, then advance.
    always_comb begin
        en_pc     = 1'b1;
        en_d      = 1'b1;
        sel_d     = 1'b0;
        clr_e     = 1'b0;
        flush_all = 1'b0;
        pc_sel    = 2'd0;
        stall     = 1'b0;
        if (exc_take) begin
            flush_all = 1'b1;
            sel_d     = 1'b1;
            clr_e     = 1'b1;
            pc_sel    = 2'd1;
        end else if (stall_raw) begin
            stall = 1'b1;
            en_pc = 1'b0;
            en_d  = 1'b0;
            clr_e = 1'b1;
        end else if (eret_d) begin
            // Redirect to EPC and squash the fall-through instruction.
            sel_d  = 1'b1;
            pc_sel = 2'd2;
        end
    end

    // Multiply/divide busy counter: start reloads (even back-to-back) unless
    // an exception squashes the starting instruction; otherwise count down.
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt <= 4'd0;
        end else if (md_start_e && !exc_req_m) begin
            cnt <= md_div_e ? DIV_LD : MULT_LD;
        end else if (cnt != 4'd0) begin
            cnt <= cnt - 4'd1;
        end
    end

    // Exception FSM: one EXC_FLUSH cycle after each taken exception.
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= NORMAL;
        end else begin
            case (state)
                NORMAL:    if (exc_req_m) state <= EXC_FLUSH;
                EXC_FLUSH: state <= NORMAL;
                default:   state <= NORMAL;
            endcase
        end
    end

endmodule
